// File: rtl/code_entry_pkg.sv
// code_entry_pkg: shared states, digit counts and widths for code entry and access control
package code_entry_pkg;
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HOLD, S_TIMEOUT} state_e;
    localparam logic [2:0] ID_DIGITS = 3'd4;
    localparam logic [2:0] PASS_DIGITS = 3'd5;
    localparam int CODE_W = 20;
    localparam int DIGIT_W = 4;
    localparam int CNT_W = 24;
    function automatic logic [2:0] target_digits(input logic mode);
        return mode ? PASS_DIGITS : ID_DIGITS;
    endfunction
endpackage

// File: rtl/code_entry_if.sv
// code_entry_if: keypad-side controls in, assembled code and status out
interface code_entry_if;
    import code_entry_pkg::*;
    logic push;
    logic [DIGIT_W-1:0] digit_in;
    logic mode;
    logic start;
    logic ack;
    logic clear;
    logic [CODE_W-1:0] code_out;
    logic code_valid;
    logic busy;
    logic [2:0] digit_count;
    logic entry_timeout;
    modport master (
        output push, digit_in, mode, start, ack, clear,
        input code_out, code_valid, busy, digit_count, entry_timeout
    );
    modport slave (
        input push, digit_in, mode, start, ack, clear,
        output code_out, code_valid, busy, digit_count, entry_timeout
    );
endinterface

// File: rtl/code_entry_entry_timer.sv
// entry_timer: clearable, enabled, saturating counter with terminal-count flag at LIMIT-1
module entry_timer #(
    parameter int W = 24,
    parameter logic [W-1:0] LIMIT = 24'd5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [W-1:0] count_q, count_d;
    always_comb begin
        count_d = clr ? '0 : (en && count_q != '1) ? count_q + 1'b1 : count_q;
    end
    always_ff @(posedge clk) begin
        if (!rst) count_q <= '0;
        else count_q <= count_d;
    end
    assign tc = count_q >= LIMIT - 1'b1;
endmodule

// File: rtl/code_entry.sv
// code_entry: collects a 4-digit ID or 5-digit password from button pushes with inactivity timeout
module code_entry
    import code_entry_pkg::*;
#(
    parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 24'd5000000
) (
    input logic clk,
    input logic rst,
    code_entry_if.slave bus
);
    state_e state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [2:0] dc_q, dc_d, n_q, n_d;
    logic busy_q, valid_q, to_q;
    logic tc, tmr_en, tmr_clr;
    assign tmr_en = state_q == S_COLLECT && dc_q != 3'd0;
    assign tmr_clr = state_q != S_COLLECT || bus.push || bus.clear;
    entry_timer #(.W(CNT_W), .LIMIT(TIMEOUT_CYCLES)) u_timer (
        .clk(clk),
        .rst(rst),
        .clr(tmr_clr),
        .en(tmr_en),
        .tc(tc)
    );
    always_comb begin
        state_d = state_q;
        code_d = code_q;
        dc_d = dc_q;
        n_d = n_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_COLLECT;
                    n_d = target_digits(bus.mode);
                    code_d = '0;
                    dc_d = 3'd0;
                end
            end
            S_COLLECT: begin
                if (bus.clear) begin
                    code_d = '0;
                    dc_d = 3'd0;
                end else if (bus.push) begin
                    code_d = {code_q[CODE_W-DIGIT_W-1:0], bus.digit_in};
                    dc_d = dc_q + 3'd1;
                    state_d = (dc_q + 3'd1 == n_q) ? S_HOLD : S_COLLECT;
                end else if (tc) begin
                    state_d = S_TIMEOUT;
                    code_d = '0;
                    dc_d = 3'd0;
                end
            end
            S_HOLD: begin
                if (bus.ack) begin
                    state_d = S_IDLE;
                    code_d = '0;
                    dc_d = 3'd0;
                end
            end
            default: state_d = S_COLLECT;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            code_q <= '0;
            dc_q <= 3'd0;
            n_q <= ID_DIGITS;
            busy_q <= 1'b0;
            valid_q <= 1'b0;
            to_q <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q <= code_d;
            dc_q <= dc_d;
            n_q <= n_d;
            busy_q <= state_d == S_COLLECT;
            valid_q <= state_d == S_HOLD;
            to_q <= state_d == S_TIMEOUT;
        end
    end
    assign bus.code_out = code_q;
    assign bus.digit_count = dc_q;
    assign bus.busy = busy_q;
    assign bus.code_valid = valid_q;
    assign bus.entry_timeout = to_q;
endmodule

// File: tb/tb_code_entry.sv
// tb_code_entry: directed self-checking bench for code_entry
module tb_code_entry;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;
    code_entry_if bus();
    code_entry #(.TIMEOUT_CYCLES(24'd16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_digit(input logic [3:0] d);
        bus.digit_in = d;
        bus.push = 1'b1;
        tick();
        bus.push = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic arm(input logic m);
        bus.mode = m;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.code_out, bus.code_valid, bus.busy, bus.digit_count, bus.entry_timeout} !== 26'd0) begin
            errors++;
            $display("FAIL reset_outputs: got code=%h v=%b b=%b dc=%0d to=%b, expected all zero", bus.code_out, bus.code_valid, bus.busy, bus.digit_count, bus.entry_timeout);
        end
        push_digit(4'h3);
        push_digit(4'h5);
        checks++;
        if (bus.digit_count !== 3'd0 || bus.code_out !== 20'h0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_push_ignored: got dc=%0d code=%h busy=%b, expected 0/0/0", bus.digit_count, bus.code_out, bus.busy);
        end
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        checks++;
        if (bus.code_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ack_ignored: got v=%b busy=%b, expected 0/0", bus.code_valid, bus.busy);
        end
    endtask

    task automatic test_user_id();
        arm(1'b0);
        checks++;
        if (bus.busy !== 1'b1 || bus.digit_count !== 3'd0) begin
            errors++;
            $display("FAIL id_armed: got busy=%b dc=%0d, expected 1/0", bus.busy, bus.digit_count);
        end
        push_digit(4'h9);
        push_digit(4'h4);
        push_digit(4'h8);
        checks++;
        if (bus.code_valid !== 1'b0 || bus.digit_count !== 3'd3 || bus.code_out !== 20'h00948) begin
            errors++;
            $display("FAIL id_partial: got v=%b dc=%0d code=%h, expected 0/3/00948", bus.code_valid, bus.digit_count, bus.code_out);
        end
        bus.mode = 1'b1;
        push_digit(4'h9);
        checks++;
        if (bus.code_out !== 20'h09489 || bus.code_valid !== 1'b1 || bus.busy !== 1'b0 || bus.digit_count !== 3'd4) begin
            errors++;
            $display("FAIL id_done: got code=%h v=%b busy=%b dc=%0d, expected 09489/1/0/4", bus.code_out, bus.code_valid, bus.busy, bus.digit_count);
        end
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        checks++;
        if (bus.code_valid !== 1'b0 || bus.busy !== 1'b0 || bus.code_out !== 20'h0 || bus.digit_count !== 3'd0) begin
            errors++;
            $display("FAIL id_ack: got v=%b busy=%b code=%h dc=%0d, expected 0/0/0/0", bus.code_valid, bus.busy, bus.code_out, bus.digit_count);
        end
    endtask

    task automatic test_password();
        arm(1'b1);
        bus.mode = 1'b0;
        push_digit(4'hA);
        push_digit(4'hB);
        push_digit(4'hC);
        push_digit(4'hD);
        checks++;
        if (bus.code_valid !== 1'b0 || bus.busy !== 1'b1 || bus.digit_count !== 3'd4) begin
            errors++;
            $display("FAIL pass_four: got v=%b busy=%b dc=%0d, expected 0/1/4", bus.code_valid, bus.busy, bus.digit_count);
        end
        push_digit(4'hE);
        checks++;
        if (bus.code_out !== 20'hABCDE || bus.code_valid !== 1'b1 || bus.digit_count !== 3'd5) begin
            errors++;
            $display("FAIL pass_done: got code=%h v=%b dc=%0d, expected ABCDE/1/5", bus.code_out, bus.code_valid, bus.digit_count);
        end
        push_digit(4'h3);
        bus.clear = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.start = 1'b0;
        checks++;
        if (bus.code_out !== 20'hABCDE || bus.code_valid !== 1'b1 || bus.digit_count !== 3'd5 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_frozen: got code=%h v=%b dc=%0d busy=%b, expected ABCDE/1/5/0", bus.code_out, bus.code_valid, bus.digit_count, bus.busy);
        end
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        checks++;
        if (bus.code_valid !== 1'b0) begin
            errors++;
            $display("FAIL pass_ack: got v=%b, expected 0", bus.code_valid);
        end
    endtask

    task automatic test_clear();
        arm(1'b0);
        push_digit(4'h1);
        push_digit(4'h2);
        bus.clear = 1'b1;
        push_digit(4'h7);
        bus.clear = 1'b0;
        checks++;
        if (bus.digit_count !== 3'd0 || bus.code_out !== 20'h0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL clear_wins: got dc=%0d code=%h busy=%b, expected 0/0/1", bus.digit_count, bus.code_out, bus.busy);
        end
        push_digit(4'h1);
        push_digit(4'h2);
        push_digit(4'h3);
        push_digit(4'h4);
        checks++;
        if (bus.code_out !== 20'h01234 || bus.code_valid !== 1'b1) begin
            errors++;
            $display("FAIL clear_reentry: got code=%h v=%b, expected 01234/1", bus.code_out, bus.code_valid);
        end
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
    endtask

    task automatic test_timeout();
        int pulses = 0;
        int at = 0;
        arm(1'b0);
        push_digit(4'h5);
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.entry_timeout === 1'b1) begin
                pulses++;
                at = i;
                checks++;
                if (bus.digit_count !== 3'd0 || bus.code_out !== 20'h0 || bus.busy !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_state: got dc=%0d code=%h busy=%b, expected 0/0/0", bus.digit_count, bus.code_out, bus.busy);
                end
            end
        end
        checks++;
        if (pulses != 1 || at != 16) begin
            errors++;
            $display("FAIL timeout_pulse: got %0d pulses at cycle %0d, expected 1 at 16", pulses, at);
        end
        checks++;
        if (bus.busy !== 1'b1 || bus.digit_count !== 3'd0) begin
            errors++;
            $display("FAIL timeout_return: got busy=%b dc=%0d, expected 1/0", bus.busy, bus.digit_count);
        end
        push_digit(4'h6);
        repeat (15) tick();
        push_digit(4'h7);
        checks++;
        if (bus.entry_timeout !== 1'b0 || bus.digit_count !== 3'd2 || bus.code_out !== 20'h00067) begin
            errors++;
            $display("FAIL tc_push_wins: got to=%b dc=%0d code=%h, expected 0/2/00067", bus.entry_timeout, bus.digit_count, bus.code_out);
        end
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.entry_timeout === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL tc_no_timeout: got %0d pulses busy=%b, expected 0/1", pulses, bus.busy);
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        arm(1'b1);
        push_digit(4'h1);
        push_digit(4'h2);
        push_digit(4'h3);
        rst = 1'b0;
        push_digit(4'h4);
        rst = 1'b1;
        checks++;
        if ({bus.code_out, bus.code_valid, bus.busy, bus.digit_count, bus.entry_timeout} !== 26'd0) begin
            errors++;
            $display("FAIL reset_mid: got code=%h v=%b b=%b dc=%0d to=%b, expected all zero", bus.code_out, bus.code_valid, bus.busy, bus.digit_count, bus.entry_timeout);
        end
        arm(1'b0);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL start_after_reset: got busy=%b, expected 1", bus.busy);
        end
        push_digit(4'h1);
        push_digit(4'h2);
        push_digit(4'h3);
        push_digit(4'h4);
        do_reset();
        checks++;
        if (bus.code_valid !== 1'b0 || bus.code_out !== 20'h0 || bus.digit_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_hold: got v=%b code=%h dc=%0d, expected 0/0/0", bus.code_valid, bus.code_out, bus.digit_count);
        end
    endtask

    initial begin
        bus.push = 1'b0;
        bus.digit_in = 4'h0;
        bus.mode = 1'b0;
        bus.start = 1'b0;
        bus.ack = 1'b0;
        bus.clear = 1'b0;
        test_reset();
        test_user_id();
        test_password();
        test_clear();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/code_entry.md
CODE_ENTRY -- requirements
Module: code_entry

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 24'd5000000, inactivity limit in clk cycles between accepted digits during entry.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 push  input  1  single-cycle pulse from button conditioner; one pulse = one digit.
REQ-005 digit_in  input  4  nibble from switches, sampled only on push.
REQ-006 mode  input  1  0 = user ID (4 digits), 1 = password (5 digits); sampled only on start.
REQ-007 start  input  1  single-cycle arm request from access controller.
REQ-008 ack  input  1  consumer has taken code_out.
REQ-009 clear  input  1  discard partial entry.
REQ-010 code_out  output  20  assembled code, first digit most significant; ID right-justified in [15:0], [19:16]=0.
REQ-011 code_valid  output  1  code_out complete and stable.
REQ-012 busy  output  1  high in COLLECT.
REQ-013 digit_count  output  3  digits accepted in current entry (0..5).
REQ-014 entry_timeout  output  1  one-cycle pulse when a partial entry is abandoned for inactivity.

Function
REQ-015 States: IDLE, COLLECT, HOLD, TIMEOUT; all outputs registered.
REQ-016 IDLE: start=1 -> COLLECT next cycle; latch mode into target N (4 or 5); code_out=0, digit_count=0.
REQ-017 COLLECT: push=1 -> code_out <= {code_out[15:0], digit_in}, digit_count+1, inactivity counter cleared.
REQ-018 Push that makes digit_count==N -> HOLD next cycle; code_valid=1 in the cycle after that final push is sampled (1-cycle latency).
REQ-019 HOLD: code_valid=1 and code_out frozen; push, clear, start ignored; ack=1 -> IDLE, code_valid=0 next cycle.
REQ-020 ack outside HOLD ignored; start outside IDLE ignored; push in IDLE/HOLD ignored.
REQ-021 mode changes after start have no effect until the next start.
REQ-022 clear=1 in COLLECT -> code_out=0, digit_count=0, counter cleared, stay COLLECT; clear wins over a simultaneous push.
REQ-023 Inactivity counter increments each COLLECT cycle only while digit_count>=1; reaching TIMEOUT_CYCLES-1 without push -> TIMEOUT.
REQ-024 push on the terminal-count cycle wins: digit accepted, counter cleared, no timeout.
REQ-025 TIMEOUT (one cycle): entry_timeout=1, code_out=0, digit_count=0, then COLLECT with same N.
REQ-026 busy=1 exactly in COLLECT; code_valid=1 exactly in HOLD.
REQ-027 Counter width 24 bits, saturates, never wraps.

Reset
REQ-028 rst=0 at any clock edge, including mid-entry or in HOLD -> state IDLE, code_out=0, code_valid=0, busy=0, digit_count=0, entry_timeout=0, counter=0, N=4.
REQ-029 Inputs ignored on the reset cycle; start on the first cycle after rst=1 is honoured.

Structure
REQ-030 Shared package holds state encodings, ID_DIGITS=4, PASS_DIGITS=5, CODE_W=20; access controller uses the same constants.
REQ-031 One sub-module, entry_timer: clearable, enabled, saturating 24-bit counter with terminal-count flag.

Verification
REQ-032 start, mode=0, pushes digits 9,4,8,9 -> code_out=20'h09489, code_valid=1 one cycle after 4th push; ack -> code_valid=0, IDLE.
REQ-033 start, mode=1, digits A,B,C,D,E -> code_out=20'hABCDE, digit_count=5, code_valid=1; extra push while in HOLD leaves code_out unchanged.
REQ-034 mode=0 digits 1,2 then clear and push 7 in same cycle -> digit_count=0, code_out=0; then 1,2,3,4 -> 20'h01234.
REQ-035 TIMEOUT_CYCLES=16, one digit then idle -> entry_timeout pulses once, digit_count=0, busy returns 1; push at terminal-count cycle -> no timeout.
REQ-036 rst=0 after 3 of 5 password digits -> all outputs zero next cycle; pushes before start ignored.
